// File: rtl/mac_accum_8x8.sv
// Pipelined unsigned multiply-accumulate over framed operand beats, fed by an
// 8x8 recursive multiplier core (2x2 -> 4x4 -> 8x8 quadrant decomposition).

module mac_accum_8x8_mul4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] pp [4];

  // Quadrant gi multiplies half (gi%2) of a by half (gi/2) of b.
  for (genvar gi = 0; gi < 4; gi++) begin : g_quad
    logic [1:0] a_s;
    logic [1:0] b_s;
    assign a_s = a[2*(gi%2) +: 2];
    assign b_s = b[2*(gi/2) +: 2];
    assign pp[gi] = {2'b00, a_s & {2{b_s[0]}}} + {1'b0, a_s & {2{b_s[1]}}, 1'b0};
  end

  assign p = {4'b0000, pp[0]} + ({4'b0000, pp[1]} << 2)
           + ({4'b0000, pp[2]} << 2) + ({4'b0000, pp[3]} << 4);
endmodule

module mac_accum_8x8_core (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] pp [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_quad
    mac_accum_8x8_mul4 u_mul4 (
      .a (a[4*(gi%2) +: 4]),
      .b (b[4*(gi/2) +: 4]),
      .p (pp[gi])
    );
  end

  assign p = {8'h00, pp[0]} + ({8'h00, pp[1]} << 4)
           + ({8'h00, pp[2]} << 4) + ({8'h00, pp[3]} << 8);
endmodule

module mac_accum_8x8 #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  typedef enum logic [1:0] {ST_ACC, ST_FLUSH, ST_DONE} state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic             s1_valid_q;
  logic             s1_last_q;
  logic [15:0]      prod_q;
  logic             s2_valid_q;
  logic             s2_last_q;
  logic [15:0]      prod_w;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum_w;
  logic             accept;
  logic             res_take;

  mac_accum_8x8_core u_core (
    .a (a_q),
    .b (b_q),
    .p (prod_w)
  );

  assign accept   = in_valid & in_ready_q;
  assign res_take = out_valid_q & out_ready;
  assign sum_w    = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, prod_q};

  // The result handshake and an accumulate never coincide: no beats are in flight in DONE.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (res_take) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (s2_valid_q) begin
      acc_d = sum_w[ACC_W-1:0];
      ovf_d = ovf_q | sum_w[ACC_W];
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      prod_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        a_q       <= in_a;
        b_q       <= in_b;
        s1_last_q <= in_last;
      end
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_valid_q & s1_last_q;
      prod_q     <= prod_w;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;

      case (state_q)
        ST_ACC: begin
          if (accept && in_last) begin
            state_q    <= ST_FLUSH;
            in_ready_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (s2_valid_q && s2_last_q) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_ACC;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_ACC;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_mac_accum_8x8.sv
// Bench for mac_accum_8x8: a 24-bit and a 16-bit accumulator instance share one
// stimulus stream; a frame-sum scoreboard supplies the expected results for both.

module tb_mac_accum_8x8;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_24, out_valid_24, out_ovf_24;
  logic [23:0] out_acc_24;
  logic [7:0]  out_count_24;
  logic        in_ready_16, out_valid_16, out_ovf_16;
  logic [15:0] out_acc_16;
  logic [7:0]  out_count_16;

  typedef struct {
    longint sum;
    int     n;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] last_acc_24, last_cnt, last_ovf_24, last_acc_16, last_ovf_16;

  always #5 clk = ~clk;

  mac_accum_8x8 #(.ACC_W(24), .CNT_W(8)) dut24 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready_24),
    .in_a (in_a), .in_b (in_b), .in_last (in_last),
    .out_valid (out_valid_24), .out_ready (out_ready),
    .out_acc (out_acc_24), .out_count (out_count_24), .out_ovf (out_ovf_24)
  );

  mac_accum_8x8 #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready_16),
    .in_a (in_a), .in_b (in_b), .in_last (in_last),
    .out_valid (out_valid_16), .out_ready (out_ready),
    .out_acc (out_acc_16), .out_count (out_count_16), .out_ovf (out_ovf_16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One beat: optional bubbles carrying junk, then hold the beat until accepted.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last,
                           input int bubbles);
    int t;
    for (int i = 0; i < bubbles; i++) begin
      in_valid = 1'b0;
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    t = 0;
    while (in_ready_24 !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", 32'(t < 100), 32'd1);
    if (t < 100) begin
      @(negedge clk);
      cur.sum += longint'(a) * longint'(b);
      cur.n++;
      if (last) begin
        sb.push_back(cur);
        cur = '{0, 0};
        chk("in_ready_flush", 32'(in_ready_24), 32'd0);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, "_valid24"}, 32'(out_valid_24), 32'd1);
    chk({tag, "_acc24"},   32'(out_acc_24),   32'(e.sum % 64'h100_0000));
    chk({tag, "_cnt24"},   32'(out_count_24), 32'((e.n > 255) ? 255 : e.n));
    chk({tag, "_ovf24"},   32'(out_ovf_24),   32'(e.sum > 64'hFF_FFFF));
    chk({tag, "_valid16"}, 32'(out_valid_16), 32'd1);
    chk({tag, "_acc16"},   32'(out_acc_16),   32'(e.sum % 64'h1_0000));
    chk({tag, "_cnt16"},   32'(out_count_16), 32'((e.n > 255) ? 255 : e.n));
    chk({tag, "_ovf16"},   32'(out_ovf_16),   32'(e.sum > 64'hFFFF));
  endtask

  // Waits for the result (called at the negedge after the last beat's accept edge).
  task automatic get_result(input int stall);
    int   w;
    exp_t e;
    out_ready = 1'b0;
    w = 0;
    while (out_valid_24 !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("latency", 32'(w), 32'd2);
    chk("sb_pending", 32'(sb.size()), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '{-1, 0};
    for (int s = 0; s <= stall; s++) begin
      check_out((s == 0) ? "res" : "hold", e);
      if (s < stall) begin
        chk("hold_in_ready", 32'(in_ready_24), 32'd0);
        @(negedge clk);
      end
    end
    last_acc_24 = 32'(out_acc_24);
    last_cnt    = 32'(out_count_24);
    last_ovf_24 = 32'(out_ovf_24);
    last_acc_16 = 32'(out_acc_16);
    last_ovf_16 = 32'(out_ovf_16);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid",    32'(out_valid_24), 32'd0);
    chk("post_in_ready", 32'({in_ready_24, in_ready_16}), 32'b11);
    chk("post_acc",      32'(out_acc_24),   32'd0);
    chk("post_cnt",      32'(out_count_24), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         len;
    bit         big;
    logic [7:0] ra, rb;

    cur = '{0, 0};
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = 8'h00;
    in_b = 8'h00;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready_24),  32'd1);
    chk("rst_out_valid", 32'(out_valid_24), 32'd0);
    chk("rst_acc",       32'(out_acc_24),   32'd0);
    chk("rst_cnt",       32'(out_count_24), 32'd0);
    chk("rst_ovf",       32'(out_ovf_24),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single maximal beat.
    send_beat(8'd255, 8'd255, 1'b1, 0);
    get_result(0);
    chk("t1_acc", last_acc_24, 32'h00FE01);
    chk("t1_cnt", last_cnt,    32'd1);
    chk("t1_ovf", last_ovf_24, 32'd0);

    // Four beats separated by two-cycle bubbles.
    send_beat(8'd3, 8'd4,  1'b0, 0);
    send_beat(8'd5, 8'd6,  1'b0, 2);
    send_beat(8'd7, 8'd8,  1'b0, 2);
    send_beat(8'd9, 8'd10, 1'b1, 2);
    get_result(0);
    chk("t2_acc", last_acc_24, 32'd188);
    chk("t2_cnt", last_cnt,    32'd4);
    chk("t2_ovf", last_ovf_24, 32'd0);

    // 16-bit wrap, with the result held off for five cycles.
    send_beat(8'd255, 8'd255, 1'b0, 0);
    send_beat(8'd255, 8'd255, 1'b1, 0);
    get_result(5);
    chk("t3_acc16", last_acc_16, 32'hFC02);
    chk("t3_ovf16", last_ovf_16, 32'd1);
    chk("t3_ovf24", last_ovf_24, 32'd0);

    send_beat(8'd2, 8'd3, 1'b1, 0);
    get_result(0);
    chk("t4_acc", last_acc_24, 32'd6);
    chk("t4_cnt", last_cnt,    32'd1);
    chk("t4_ovf", last_ovf_24, 32'd0);

    // Asynchronous reset in the middle of a frame.
    send_beat(8'd10, 8'd20, 1'b0, 0);
    send_beat(8'd30, 8'd40, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("t5_partial_acc", 32'(out_acc_24),   32'd1400);
    chk("t5_partial_cnt", 32'(out_count_24), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_acc",      32'(out_acc_24),   32'd0);
    chk("t5_rst_cnt",      32'(out_count_24), 32'd0);
    chk("t5_rst_valid",    32'(out_valid_24), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready_24),  32'd1);
    cur = '{0, 0};
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(8'd1, 8'd1, 1'b1, 0);
    get_result(0);
    chk("t5_acc", last_acc_24, 32'd1);
    chk("t5_cnt", last_cnt,    32'd1);

    // Long frame: count saturates and the 24-bit accumulator wraps.
    for (int k = 0; k < 260; k++) send_beat(8'd255, 8'd255, k == 259, 0);
    get_result(1);
    chk("t6_acc", last_acc_24, 32'd129284);
    chk("t6_cnt", last_cnt,    32'd255);
    chk("t6_ovf", last_ovf_24, 32'd1);

    // Random frames with bubbles and result stalls.
    for (int f = 0; f < 300 && fails < 50; f++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 300) : $urandom_range(1, 20);
      big = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        ra = big ? 8'($urandom_range(200, 255)) : 8'($urandom);
        rb = big ? 8'($urandom_range(200, 255)) : 8'($urandom);
        send_beat(ra, rb, k == len - 1,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
      get_result(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
